// File: rtl/hack_rom_loader.sv
// Boot loader for the Hack instruction ROM: parses a length/data/checksum byte stream,
// writes each word sequentially from address 0 and releases the CPU on a good checksum.
module hack_rom_loader #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StCsum, StDone, StError
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d, len_new;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [7:0]          csum_q, csum_d, hi_q, hi_d;
  logic                byte_ready_d, mem_we_d, cpu_reset_d, busy_d, done_d, error_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [15:0]         mem_wdata_d;
  logic                xfer;

  assign xfer    = byte_valid & byte_ready;
  assign len_new = {len_q[15:8], byte_in};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_reset_d = cpu_reset;
    busy_d      = busy;
    done_d      = done;
    error_d     = error;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d     = StLenHi;
          busy_d      = 1'b1;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          mem_addr_d  = '0;
          cnt_d       = '0;
          csum_d      = '0;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d   = {byte_in, len_q[7:0]};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new == 16'd0 || 32'(len_new) > MAX_WORDS) begin
            state_d = StError;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (xfer) begin
          hi_d    = byte_in;
          csum_d  = csum_q + byte_in;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (xfer) begin
          mem_wdata_d = {hi_q, byte_in};
          csum_d      = csum_q + byte_in;
          mem_we_d    = 1'b1;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        mem_addr_d = mem_addr + ADDR_W'(1);
        cnt_d      = cnt_q + (ADDR_W + 1)'(1);
        state_d    = (32'(cnt_q) + 32'd1 == 32'(len_q)) ? StCsum : StDataHi;
      end
      StCsum: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (byte_in == csum_q) begin
            state_d     = StDone;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = StError;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Ready is registered, so it is derived from the state being entered.
    byte_ready_d = (state_d == StLenHi) || (state_d == StLenLo) || (state_d == StDataHi) ||
                   (state_d == StDataLo) || (state_d == StCsum);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      hi_q       <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      hi_q       <= hi_d;
      byte_ready <= byte_ready_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_reset  <= cpu_reset_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Table-driven bench for hack_rom_loader with a write scoreboard fed by the stream driver.
module tb_hack_rom_loader;
  localparam int unsigned AW = 15;

  logic          clk = 1'b0;
  logic          reset_n, start, byte_valid, byte_ready, mem_we;
  logic [7:0]    byte_in;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_reset, busy, done, error;

  hack_rom_loader #(.ADDR_W(AW), .MAX_WORDS(32768)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic [95:0] stream;     // bytes MSB-first
    int          nbytes;
    bit          exp_done;
    int          exp_writes;
  } vec_t;

  vec_t vecs[6];
  wr_t  exp_q[$];
  int   wtimes[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   nwrites  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected one.
  wr_t e;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      nwrites++;
      wtimes.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write addr", 32'(mem_addr), 32'(e.addr));
        check("write data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic check_reset_vals();
    check("rst byte_ready", 32'(byte_ready), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_wdata", 32'(mem_wdata), 0);
    check("rst cpu_reset", 32'(cpu_reset), 1);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst error", 32'(error), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited = 0;
    if (stall) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte accept timeout: byte_ready %b expected 1", byte_ready);
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int v, input bit stall, input bit mid_start);
    logic [7:0] b, prev;
    wr_t        w;
    nwrites = 0;
    wtimes.delete();
    pulse_start();
    check("start busy", 32'(busy), 1);
    check("start cpu_reset", 32'(cpu_reset), 1);
    check("start done", 32'(done), 0);
    check("start error", 32'(error), 0);
    check("start byte_ready", 32'(byte_ready), 1);
    prev = 8'h00;
    for (int i = 0; i < vecs[v].nbytes; i++) begin
      b = vecs[v].stream[95-8*i -: 8];
      if (i >= 3 && i <= vecs[v].nbytes - 2 && (i % 2) == 1) begin
        w.addr = AW'((i - 3) / 2);
        w.data = {prev, b};
        exp_q.push_back(w);
      end
      send_byte(b, stall);
      if (mid_start && i == 3) pulse_start();
      prev = b;
    end
    byte_valid = 1'b0;
    check("end done", 32'(done), 32'(vecs[v].exp_done));
    check("end error", 32'(error), 32'(!vecs[v].exp_done));
    check("end cpu_reset", 32'(cpu_reset), 32'(!vecs[v].exp_done));
    check("end busy", 32'(busy), 0);
    check("write count", 32'(nwrites), 32'(vecs[v].exp_writes));
    check("pending writes", 32'(exp_q.size()), 0);
    if (!stall) begin
      for (int k = 1; k < wtimes.size(); k++)
        check("word period", 32'(wtimes[k] - wtimes[k-1]), 3);
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{{72'h00031234ABCD0007C5, 24'h0}, 9, 1'b1, 3};
    vecs[1] = '{{72'h00031234ABCD0007C4, 24'h0}, 9, 1'b0, 3};
    vecs[2] = '{{16'h0000, 80'h0}, 2, 1'b0, 0};
    vecs[3] = '{{16'h8001, 80'h0}, 2, 1'b0, 0};
    vecs[4] = '{{40'h0001FFFFFE, 56'h0}, 5, 1'b1, 1};
    vecs[5] = '{{56'h00020001000203, 40'h0}, 7, 1'b1, 2};

    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    @(posedge clk); #1;
    check_reset_vals();
    reset_n = 1'b1;

    // Idle with valid asserted and no start: nothing accepted, nothing written.
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    repeat (4) begin
      @(posedge clk); #1;
      check("idle byte_ready", 32'(byte_ready), 0);
    end
    byte_valid = 1'b0;
    check("idle writes", 32'(nwrites), 0);

    for (int v = 0; v < 6; v++) run_vec(v, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 check("done holds cpu_reset low", 32'(cpu_reset), 0);

    run_vec(0, 1'b1, 1'b0);
    run_vec(0, 1'b0, 1'b1);

    // Max legal length is accepted; then reset after the first write.
    nwrites = 0;
    pulse_start();
    send_byte(8'h80, 1'b0);
    send_byte(8'h00, 1'b0);
    check("len 8000 busy", 32'(busy), 1);
    check("len 8000 error", 32'(error), 0);
    check("len 8000 byte_ready", 32'(byte_ready), 1);
    exp_q.push_back(wr_t'{addr: AW'(0), data: 16'hBEEF});
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    byte_valid = 1'b0;
    check("first word mem_we", 32'(mem_we), 1);
    @(posedge clk); #1;
    check("addr after write", 32'(mem_addr), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();
    reset_n = 1'b1;
    check("pending after abort", 32'(exp_q.size()), 0);
    run_vec(0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
